mem_port_arbiter: RTL and testbench

- Shares the single SRAM-style memory port between the instruction-fetch requester and the MEM-stage data requester.
- Accepts at most one transaction at a time, latches its fields, and drives the shared bus with a req/addr_ok/data_ok handshake.
- Routes the response back to whichever requester owns the transaction.
- Data requests win by default; a starvation counter guarantees fetch progress.

---
 rtl/mem_port_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-style memory port between the fetch and MEM-stage requesters.
// One transaction in flight at a time; data wins by default, a counter protects fetch.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state_r;
  state_t      state_nxt_s;
  logic        owner_r;
  logic [3:0]  starve_cnt_r;
  logic [3:0]  starve_nxt_s;
  logic        grant_inst_s;
  logic        accept_s;
  logic        resp_s;
  logic        sel_wr_s;
  logic [1:0]  sel_size_s;
  logic [3:0]  sel_wstrb_s;
  logic [31:0] sel_addr_s;
  logic [31:0] sel_wdata_s;

  assign grant_inst_s = inst_req & (~data_req | (starve_cnt_r == LIMIT));
  // resetn gates the handshakes so nothing is acknowledged while reset is held
  assign accept_s     = resetn & (state_r == IDLE) & (inst_req | data_req);
  assign resp_s       = resetn & (state_r == DATA) & bus_data_ok;

  // Next-state decode for the transaction FSM
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (inst_req | data_req) begin
          state_nxt_s = ADDR;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ADDR: begin
        if (bus_addr_ok) begin
          state_nxt_s = DATA;
        end else begin
          state_nxt_s = ADDR;
        end
      end
      DATA: begin
        if (bus_data_ok) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DATA;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Winner field mux and starvation counter update for an IDLE grant
  always_comb begin
    sel_wr_s     = data_wr;
    sel_size_s   = data_size;
    sel_wstrb_s  = data_wstrb;
    sel_addr_s   = data_addr;
    sel_wdata_s  = data_wdata;
    starve_nxt_s = 4'd0;
    if (grant_inst_s) begin
      sel_wr_s    = inst_wr;
      sel_size_s  = inst_size;
      sel_wstrb_s = inst_wstrb;
      sel_addr_s  = inst_addr;
      sel_wdata_s = inst_wdata;
    end else begin
      sel_wr_s    = data_wr;
      sel_size_s  = data_size;
      sel_wstrb_s = data_wstrb;
      sel_addr_s  = data_addr;
      sel_wdata_s = data_wdata;
    end
    if (!grant_inst_s && inst_req) begin
      starve_nxt_s = (starve_cnt_r == LIMIT) ? starve_cnt_r : (starve_cnt_r + 4'd1);
    end else begin
      starve_nxt_s = 4'd0;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Transaction fields, owner and starvation count captured on acceptance only
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      owner_r      <= 1'b0;
      starve_cnt_r <= 4'd0;
      bus_wr       <= 1'b0;
      bus_size     <= 2'd0;
      bus_wstrb    <= 4'd0;
      bus_addr     <= 32'd0;
      bus_wdata    <= 32'd0;
    end else if (accept_s) begin
      owner_r      <= ~grant_inst_s;
      starve_cnt_r <= starve_nxt_s;
      bus_wr       <= sel_wr_s;
      bus_size     <= sel_size_s;
      bus_wstrb    <= sel_wstrb_s;
      bus_addr     <= sel_addr_s;
      bus_wdata    <= sel_wdata_s;
    end else begin
      owner_r      <= owner_r;
      starve_cnt_r <= starve_cnt_r;
      bus_wr       <= bus_wr;
      bus_size     <= bus_size;
      bus_wstrb    <= bus_wstrb;
      bus_addr     <= bus_addr;
      bus_wdata    <= bus_wdata;
    end
  end

  assign bus_req      = (state_r == ADDR);
  assign inst_addr_ok = accept_s & grant_inst_s;
  assign data_addr_ok = accept_s & ~grant_inst_s;
  assign inst_data_ok = resp_s & ~owner_r;
  assign data_data_ok = resp_s & owner_r;
  // Consumers qualify read data with their own data_ok
  assign inst_rdata   = bus_rdata;
  assign data_rdata   = bus_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter: per-cycle vector table
// plus hand-written starvation, wait-state store and mid-transaction reset sequences.
module tb_mem_port_arbiter;

  localparam logic [31:0] IADDR = 32'hBFC0_0000;
  localparam logic [31:0] DADDR = 32'h1C00_0010;

  logic        clk;
  logic        resetn;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [3:0]  inst_wstrb;
  logic [31:0] inst_addr, inst_wdata;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_addr_ok, bus_data_ok;
  logic [31:0] bus_rdata;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_wstrb(bus_wstrb),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ireq;
    logic        dreq;
    logic        baok;
    logic        bdok;
    logic [31:0] rdata;
    logic        e_iaok;
    logic        e_daok;
    logic        e_breq;
    logic        e_idok;
    logic        e_ddok;
    logic [31:0] e_baddr;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic chk_oks(input string name, input logic iaok, input logic daok,
                         input logic idok, input logic ddok);
    chk({name, "_inst_addr_ok"}, {31'd0, inst_addr_ok}, {31'd0, iaok});
    chk({name, "_data_addr_ok"}, {31'd0, data_addr_ok}, {31'd0, daok});
    chk({name, "_inst_data_ok"}, {31'd0, inst_data_ok}, {31'd0, idok});
    chk({name, "_data_data_ok"}, {31'd0, data_data_ok}, {31'd0, ddok});
  endtask

  logic [3:0] exp_cnt;
  logic       exp_inst;
  int         pulses;

  initial begin
    resetn = 1'b0;
    inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'd2; inst_wstrb = 4'hF;
    inst_addr = IADDR; inst_wdata = 32'd0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd2; data_wstrb = 4'hF;
    data_addr = DADDR; data_wdata = 32'd0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'd0;

    // ---------------- reset state with requests pending ----------------
    inst_req = 1'b1; data_req = 1'b1;
    repeat (2) tick();
    settle();
    chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk_oks("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_starve", {28'd0, dut.starve_cnt_r}, 32'd0);
    inst_req = 1'b0; data_req = 1'b0;
    tick();
    resetn = 1'b1;
    tick();

    // ---------------- per-cycle vector table ----------------
    //          ireq  dreq  baok  bdok  rdata         iaok  daok  breq  idok  ddok  bus_addr
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'd0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'd0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, DADDR};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'd0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, DADDR};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, DADDR};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'd0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, DADDR};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h0BAD0BAD, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, DADDR};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, DADDR};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'd0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b0, DADDR};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'd0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, IADDR};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, IADDR};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'd0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, IADDR};

    for (int i = 0; i < 12; i++) begin
      inst_req = vecs[i].ireq; data_req = vecs[i].dreq;
      bus_addr_ok = vecs[i].baok; bus_data_ok = vecs[i].bdok; bus_rdata = vecs[i].rdata;
      settle();
      chk($sformatf("vec%0d", i), {26'd0, inst_addr_ok, data_addr_ok, bus_req,
                                   inst_data_ok, data_data_ok, 1'b0},
          {26'd0, vecs[i].e_iaok, vecs[i].e_daok, vecs[i].e_breq,
           vecs[i].e_idok, vecs[i].e_ddok, 1'b0});
      chk($sformatf("vec%0d_bus_addr", i), bus_addr, vecs[i].e_baddr);
      if (vecs[i].e_ddok) chk($sformatf("vec%0d_data_rdata", i), data_rdata, vecs[i].rdata);
      else if (vecs[i].e_idok) chk($sformatf("vec%0d_inst_rdata", i), inst_rdata, vecs[i].rdata);
      tick();
    end
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0;

    // ---------------- starvation: both requesters held high ----------------
    inst_req = 1'b1; data_req = 1'b1;
    for (int g = 0; g < 6; g++) begin
      exp_cnt  = (g < 5) ? 4'(g) : 4'd0;
      exp_inst = (g == 4);
      settle();
      chk($sformatf("starve%0d_cnt", g), {28'd0, dut.starve_cnt_r}, {28'd0, exp_cnt});
      chk_oks($sformatf("starve%0d_grant", g), exp_inst, ~exp_inst, 1'b0, 1'b0);
      tick();
      bus_addr_ok = 1'b1;
      settle();
      chk($sformatf("starve%0d_addr", g), bus_addr, exp_inst ? IADDR : DADDR);
      chk_oks($sformatf("starve%0d_addrph", g), 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      bus_addr_ok = 1'b0; bus_data_ok = 1'b1;
      settle();
      chk_oks($sformatf("starve%0d_resp", g), 1'b0, 1'b0, exp_inst, ~exp_inst);
      tick();
      bus_data_ok = 1'b0;
    end
    settle();
    chk("starve_after_inst_cnt", {28'd0, dut.starve_cnt_r}, 32'd1);
    inst_req = 1'b0; data_req = 1'b0;
    tick();

    // ---------------- store with address wait states ----------------
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0; data_wstrb = 4'b0100;
    data_addr = 32'h1C00_0020; data_wdata = 32'h00AB_0000;
    settle();
    chk("store_accept", {31'd0, data_addr_ok}, 32'd1);
    tick();
    data_wr = 1'b0; data_size = 2'd2; data_wstrb = 4'hF;
    data_addr = 32'h0000_0000; data_wdata = 32'hFFFF_FFFF;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      bus_addr_ok = (c == 3);
      bus_data_ok = (c == 5);
      if (c == 4) data_req = 1'b0;
      settle();
      if (data_data_ok) pulses++;
      chk($sformatf("store_c%0d_fields", c), {bus_wr, bus_size, bus_wstrb, 25'd0}, {1'b1, 2'd0, 4'b0100, 25'd0});
      chk($sformatf("store_c%0d_addr", c), bus_addr, 32'h1C00_0020);
      chk($sformatf("store_c%0d_wdata", c), bus_wdata, 32'h00AB_0000);
      chk($sformatf("store_c%0d_bus_req", c), {31'd0, bus_req}, (c < 4) ? 32'd1 : 32'd0);
      chk($sformatf("store_c%0d_data_addr_ok", c), {31'd0, data_addr_ok}, 32'd0);
      tick();
    end
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
    settle();
    if (data_data_ok) pulses++;
    chk("store_data_ok_pulses", pulses, 32'd1);
    data_wr = 1'b0; data_size = 2'd2; data_wstrb = 4'hF; data_addr = DADDR; data_wdata = 32'd0;
    tick();

    // ---------------- reset while in DATA ----------------
    data_req = 1'b1;
    settle();
    chk("rstdata_accept", {31'd0, data_addr_ok}, 32'd1);
    tick();
    data_req = 1'b0; bus_addr_ok = 1'b1;
    tick();
    bus_addr_ok = 1'b0; inst_req = 1'b1; data_req = 1'b1; bus_data_ok = 1'b1;
    resetn = 1'b0;
    settle();
    chk("rstdata_bus_req", {31'd0, bus_req}, 32'd0);
    chk_oks("rstdata_hold", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rstdata_bus_addr", bus_addr, 32'd0);
    tick();
    inst_req = 1'b0; data_req = 1'b0;
    resetn = 1'b1;
    settle();
    chk_oks("rstdata_late_resp", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    bus_data_ok = 1'b0; data_req = 1'b1;
    settle();
    chk("rstdata_idle_accept", {31'd0, data_addr_ok}, 32'd1);
    tick();
    data_req = 1'b0;
    settle();
    chk("rstdata_bus_req_after", {31'd0, bus_req}, 32'd1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
